// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: store funct3 encodings, store-unit state encoding
// and byte-enable patterns. The load-side extract logic uses the same funct3 constants.
package riscv_mem_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } sdu_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Store lane formatter: funct3/addr[1:0]/rs2 -> replicated write data, byte enables, error flags.
// Purely combinational, no latency, no backpressure. Misalignment is only flagged when
// MISALIGN_TRAP_EN is defined; otherwise SH/SW ignore the low address bits they do not use.
module store_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wd,
    output logic [3:0]  o_be,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic w_mis_half;
    logic w_mis_word;

`ifdef MISALIGN_TRAP_EN
    assign w_mis_half = i_addr_lo[0];
    assign w_mis_word = |i_addr_lo;
`else
    assign w_mis_half = 1'b0;
    assign w_mis_word = 1'b0;
`endif

    always_comb begin
        o_wd         = i_wdata;
        o_be         = 4'b0000;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_SB: begin
                o_be = BE_BYTE0 << i_addr_lo;
                o_wd = {4{i_wdata[7:0]}};
            end
            F3_SH: begin
                o_be         = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_wd         = {2{i_wdata[15:0]}};
                o_misaligned = w_mis_half;
            end
            F3_SW: begin
                o_be         = BE_WORD;
                o_misaligned = w_mis_word;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_data_unit.sv
// Store data unit: formats rs2 into byte lanes and drives the data-memory write port.
// Latency: mem_we from the cycle after start; done/fault one cycle after the write ends; min 3 cycles.
// Backpressure: holds mem_we/payload stable until mem_ready, faults after TIMEOUT cycles (MISALIGN_TRAP_EN adds alignment trap).
module store_data_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_be
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sdu_state_e       r_state;
    sdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wd;
    logic [3:0]       r_mem_be;

    logic [31:0]      w_wd;
    logic [3:0]       w_be;
    logic             w_misaligned;
    logic             w_illegal;
    logic             w_accept;

    store_lane_align u_align (
        .i_funct3     (funct3),
        .i_addr_lo    (addr[1:0]),
        .i_wdata      (wdata_in),
        .o_wd         (w_wd),
        .o_be         (w_be),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        fault       = 1'b0;
        mem_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_illegal || w_misaligned) ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_we = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                fault       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter sits at zero whenever idle, so every new ISSUE starts a fresh wait window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE && !mem_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state != ST_ISSUE) begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_mem_be   <= '0;
        end else if (w_accept) begin
            r_mem_addr <= {addr[31:2], 2'b00};
            r_mem_wd   <= w_wd;
            r_mem_be   <= w_be;
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign mem_be   = r_mem_be;

endmodule

// File: tb/tb_store_data_unit.sv
// Bench for store_data_unit: directed cases plus random stores against a lane/timeout model.
module tb_store_data_unit;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic        fault;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    store_data_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .addr      (addr),
        .wdata_in  (wdata_in),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_be    (mem_be)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what a store of this width/address should put on the bus.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, output bit rej,
                                  output logic [31:0] ewd, output logic [3:0] ebe);
        int lane;
        lane = int'(a % 32'd4);
        rej  = 1'b0;
        ewd  = 32'h0;
        ebe  = 4'h0;
        if (f3 == 3'd0) begin
            ebe = 4'(1 << lane);
            ewd = (d & 32'hFF) * 32'h01010101;
        end else if (f3 == 3'd1) begin
            ebe = (lane >= 2) ? 4'd12 : 4'd3;
            ewd = (d & 32'hFFFF) * 32'h00010001;
`ifdef MISALIGN_TRAP_EN
            rej = (lane % 2) != 0;
`endif
        end else if (f3 == 3'd2) begin
            ebe = 4'd15;
            ewd = d;
`ifdef MISALIGN_TRAP_EN
            rej = lane != 0;
`endif
        end else begin
            rej = 1'b1;
        end
    endfunction

    // ready_lat: ISSUE cycles with mem_ready low before it rises (>= TIMEOUT means never).
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int ready_lat, input bit extra_start);
        bit          rej;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        int          exp_cycles;
        int          we_cycles;
        bit          bad;
        model(f3, a, d, rej, ewd, ebe);
        if (rej) exp_cycles = 0;
        else if (ready_lat < TIMEOUT) exp_cycles = ready_lat + 1;
        else exp_cycles = TIMEOUT;

        start = 1'b1; funct3 = f3; addr = a; wdata_in = d; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        we_cycles = 0;
        bad = 1'b0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            if (mem_we !== 1'b1) break;
            we_cycles++;
            if (mem_addr !== (a & 32'hFFFFFFFC) || mem_wd !== ewd || mem_be !== ebe ||
                busy !== 1'b1 || done !== 1'b0 || fault !== 1'b0)
                bad = 1'b1;
            start = 1'b0;
            if (extra_start && k == 1) begin
                start = 1'b1; funct3 = 3'd0; addr = 32'h0000_0F01; wdata_in = 32'h0BAD_F00D;
            end
            mem_ready = (k == ready_lat);
            tick();
        end
        start = 1'b0;
        mem_ready = 1'b0;
        chk({tag, "_we_cycles"}, 32'(we_cycles), 32'(exp_cycles));
        chk({tag, "_payload_stable"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'((!rej && ready_lat < TIMEOUT) ? 1 : 0));
        chk({tag, "_fault"}, 32'(fault), 32'((rej || ready_lat >= TIMEOUT) ? 1 : 0));
        tick();
        chk({tag, "_idle"}, {29'd0, busy, done, fault}, 32'd0);
        tick();
        chk({tag, "_no_extra_write"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        reset = 1'b0; start = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata_in = 32'h0; mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_done",  32'(done),   32'd0);
        chk("rst_fault", 32'(fault),  32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr,    32'd0);
        chk("rst_wd",    mem_wd,      32'd0);
        chk("rst_be",    32'(mem_be), 32'd0);
        reset = 1'b1;
        tick();

        // Directed: lane placement, wait states, timeout, illegal width, alignment.
        run_store("sb_1003",  3'b000, 32'h0000_1003, 32'hAABBCC5A, 0, 1'b0);
        chk("sb_be_hi", 32'(mem_be), 32'h8);
        chk("sb_wd",    mem_wd,      32'h5A5A5A5A);
        chk("sb_addr",  mem_addr,    32'h0000_1000);
        run_store("sh_2002",  3'b001, 32'h0000_2002, 32'h1234BEEF, 3, 1'b0);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wd", mem_wd,      32'hBEEFBEEF);
        run_store("sw_tmo",   3'b010, 32'h0000_4000, 32'hCAFEF00D, 1000, 1'b0);
        run_store("sw_last",  3'b010, 32'h0000_4004, 32'h01234567, TIMEOUT - 1, 1'b0);
        run_store("f3_011",   3'b011, 32'h0000_5000, 32'h11111111, 0, 1'b0);
        run_store("sw_3001",  3'b010, 32'h0000_3001, 32'hDEADBEEF, 0, 1'b0);
        run_store("sh_odd",   3'b001, 32'h0000_3001, 32'h0000A5C3, 1, 1'b0);
        run_store("busy_start", 3'b010, 32'h0000_6000, 32'h87654321, 3, 1'b1);

        // Reset in the middle of a pending write.
        start = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000; wdata_in = 32'h5555AAAA;
        tick();
        start = 1'b0;
        tick();
        chk("mid_we_before", 32'(mem_we), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_flags", {28'd0, busy, done, fault, mem_we}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wd",   mem_wd,   32'd0);
        chk("mid_rst_be",   32'(mem_be), 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_after", {28'd0, busy, done, fault, mem_we}, 32'd0);

        // Random stores against the model.
        for (int i = 0; i < 40; i++) begin
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            a  = $urandom;
            d  = $urandom;
            run_store("rand", f3, a, d, int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
